// File: rtl/cu_pkg.sv
// ---------------------------------------------------------------------------
// cu_pkg
// Shared definitions for the accumulator-machine control unit.
//   - cu_state_e : FSM state codes (also exported on the debug 'state' port)
//   - OP_*       : instruction opcodes taken from IR[7:5]
//   - ASEL_*     : A-register source select encodings (used by the A register
//                  and by testbenches)
// Optional feature macro handled by users of this package:
//   CU_ENTER_HANDSHAKE_EN (INPUT waits for the operator Enter strobe)
// ---------------------------------------------------------------------------
package cu_pkg;

    typedef enum logic [3:0] {
        ST_START  = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_LOAD   = 4'd3,
        ST_STORE  = 4'd4,
        ST_ADD    = 4'd5,
        ST_SUB    = 4'd6,
        ST_INPUT  = 4'd7,
        ST_JZ     = 4'd8,
        ST_JPOS   = 4'd9,
        ST_HALT   = 4'd10
    } cu_state_e;

    localparam logic [2:0] OP_HALT  = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_STORE = 3'b010;
    localparam logic [2:0] OP_ADD   = 3'b011;
    localparam logic [2:0] OP_SUB   = 3'b100;
    localparam logic [2:0] OP_INPUT = 3'b101;
    localparam logic [2:0] OP_JZ    = 3'b110;
    localparam logic [2:0] OP_JPOS  = 3'b111;

    localparam logic [1:0] ASEL_ALU   = 2'b00;
    localparam logic [1:0] ASEL_INPUT = 2'b01;
    localparam logic [1:0] ASEL_MEM   = 2'b10;
    localparam logic [1:0] ASEL_RSVD  = 2'b11;

endpackage

// File: rtl/cu_decode.sv
// ---------------------------------------------------------------------------
// cu_decode
// Next-state logic for the control unit FSM (purely combinational).
// Ports:
//   i_state      [3:0]  current registered state (cu_state_e code)
//   i_opcode     [2:0]  IR[7:5], consulted only in DECODE
//   i_aeq0              A == 0 (does not alter sequencing)
//   i_apos              A > 0  (does not alter sequencing)
//   i_enter             operator data-valid, consulted only in INPUT
//   o_next_state [3:0]  state to load on the next rising edge
// Macro: CU_ENTER_HANDSHAKE_EN -> INPUT waits in place until i_enter = 1.
// ---------------------------------------------------------------------------
module cu_decode
    import cu_pkg::*;
(
    input  logic [3:0] i_state,
    input  logic [2:0] i_opcode,
    input  logic       i_aeq0,
    input  logic       i_apos,
    input  logic       i_enter,
    output logic [3:0] o_next_state
);

    // Branch flags only steer PCload inside the execute state; the sequence
    // is always JZ/JPOS -> FETCH, so they are deliberately not consumed here.
    logic w_unused_inputs;
`ifdef CU_ENTER_HANDSHAKE_EN
    assign w_unused_inputs = i_aeq0 ^ i_apos;
`else
    assign w_unused_inputs = i_aeq0 ^ i_apos ^ i_enter;
`endif

    // Next-state selection
    always_comb begin
        o_next_state = ST_START;
        case (i_state)
            ST_START:  o_next_state = ST_FETCH;
            ST_FETCH:  o_next_state = ST_DECODE;
            ST_DECODE: begin
                case (i_opcode)
                    OP_HALT:  o_next_state = ST_HALT;
                    OP_LOAD:  o_next_state = ST_LOAD;
                    OP_STORE: o_next_state = ST_STORE;
                    OP_ADD:   o_next_state = ST_ADD;
                    OP_SUB:   o_next_state = ST_SUB;
                    OP_INPUT: o_next_state = ST_INPUT;
                    OP_JZ:    o_next_state = ST_JZ;
                    OP_JPOS:  o_next_state = ST_JPOS;
                    default:  o_next_state = ST_HALT;
                endcase
            end
            ST_LOAD:   o_next_state = ST_FETCH;
            ST_STORE:  o_next_state = ST_FETCH;
            ST_ADD:    o_next_state = ST_FETCH;
            ST_SUB:    o_next_state = ST_FETCH;
            ST_INPUT: begin
`ifdef CU_ENTER_HANDSHAKE_EN
                if (i_enter) begin
                    o_next_state = ST_FETCH;
                end else begin
                    o_next_state = ST_INPUT;
                end
`else
                o_next_state = ST_FETCH;
`endif
            end
            ST_JZ:     o_next_state = ST_FETCH;
            ST_JPOS:   o_next_state = ST_FETCH;
            ST_HALT:   o_next_state = ST_HALT;
            // Illegal codes restart the instruction sequence cleanly.
            default:   o_next_state = ST_START;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
// Moore FSM sequencer for a small accumulator CPU (FETCH/DECODE/execute).
// Ports:
//   clk               rising-edge clock
//   reset             asynchronous active-low reset
//   opcode [2:0]      IR[7:5]
//   Aeq0, Apos        A-register flags, used only in JZ / JPOS
//   Enter             operator data-valid for INPUT
//   IRload, PCload, JMPmux, Meminst, MemWr, Asel[1:0], Aload, Sub, Halt
//                     datapath controls
//   state [3:0]       current state code (debug)
// Macro: CU_ENTER_HANDSHAKE_EN -> INPUT holds with Aload=0 until Enter=1;
//        when undefined, Enter is ignored and INPUT loads A for one cycle.
// ---------------------------------------------------------------------------
module control_unit
    import cu_pkg::*;
#(
    parameter int OPCODE_W = 3
)(
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                Aeq0,
    input  logic                Apos,
    input  logic                Enter,
    output logic                IRload,
    output logic                PCload,
    output logic                JMPmux,
    output logic                Meminst,
    output logic                MemWr,
    output logic [1:0]          Asel,
    output logic                Aload,
    output logic                Sub,
    output logic                Halt,
    output logic [3:0]          state
);

    cu_state_e  r_state;
    logic       r_rst_sync;
    logic [3:0] w_next_state;

    cu_decode u_decode (
        .i_state      (r_state),
        .i_opcode     (opcode),
        .i_aeq0       (Aeq0),
        .i_apos       (Apos),
        .i_enter      (Enter),
        .o_next_state (w_next_state)
    );

    // State register; r_rst_sync releases reset on a clock edge so START
    // is held for one full cycle and the first FETCH lands on the second
    // rising edge after reset deasserts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rst_sync <= 1'b0;
            r_state    <= ST_START;
        end else if (!r_rst_sync) begin
            r_rst_sync <= 1'b1;
            r_state    <= ST_START;
        end else begin
            r_rst_sync <= 1'b1;
            r_state    <= cu_state_e'(w_next_state);
        end
    end

    assign state = r_state;

    // Output decode from the registered state; only the branch flags and
    // (optionally) Enter qualify outputs, and only in their own state.
    always_comb begin
        IRload  = 1'b0;
        PCload  = 1'b0;
        JMPmux  = 1'b0;
        Meminst = 1'b0;
        MemWr   = 1'b0;
        Asel    = ASEL_ALU;
        Aload   = 1'b0;
        Sub     = 1'b0;
        Halt    = 1'b0;
        case (r_state)
            ST_START:  Halt = 1'b0;
            ST_FETCH: begin
                IRload  = 1'b1;
                PCload  = 1'b1;
                JMPmux  = 1'b0;
                Meminst = 1'b1;
            end
            ST_DECODE: Meminst = 1'b0;
            ST_LOAD: begin
                Asel  = ASEL_MEM;
                Aload = 1'b1;
            end
            ST_STORE: begin
                MemWr   = 1'b1;
                Meminst = 1'b0;
            end
            ST_ADD: begin
                Asel  = ASEL_ALU;
                Sub   = 1'b0;
                Aload = 1'b1;
            end
            ST_SUB: begin
                Asel  = ASEL_ALU;
                Sub   = 1'b1;
                Aload = 1'b1;
            end
            ST_INPUT: begin
                Asel  = ASEL_INPUT;
`ifdef CU_ENTER_HANDSHAKE_EN
                Aload = Enter;
`else
                Aload = 1'b1;
`endif
            end
            ST_JZ: begin
                JMPmux = 1'b1;
                PCload = Aeq0;
            end
            ST_JPOS: begin
                JMPmux = 1'b1;
                PCload = Apos;
            end
            ST_HALT:   Halt = 1'b1;
            default:   Halt = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit
// Directed bench: each instruction is expanded into its expected per-cycle
// control words, queued, and compared against the DUT on every negedge.
// ---------------------------------------------------------------------------
module tb_control_unit;
    import cu_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] opcode;
    logic       Aeq0, Apos, Enter;
    logic       IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub, Halt;
    logic [1:0] Asel;
    logic [3:0] state;

    control_unit #(.OPCODE_W(3)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .Aeq0(Aeq0), .Apos(Apos),
        .Enter(Enter), .IRload(IRload), .PCload(PCload), .JMPmux(JMPmux),
        .Meminst(Meminst), .MemWr(MemWr), .Asel(Asel), .Aload(Aload),
        .Sub(Sub), .Halt(Halt), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       irload;
        logic       pcload;
        logic       jmpmux;
        logic       meminst;
        logic       memwr;
        logic [1:0] asel;
        logic       aload;
        logic       sub;
        logic       halt;
        logic [3:0] st;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    logic [13:0] act;
    assign act = {IRload, PCload, JMPmux, Meminst, MemWr, Asel, Aload, Sub, Halt, state};

    task automatic check(input string nm, input logic [13:0] a, input logic [13:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, a, e, $time);
        end
    endtask

    function automatic exp_t mk(input logic irl, input logic pcl, input logic jmp,
                                input logic mi, input logic mw, input logic [1:0] as,
                                input logic al, input logic sb, input logic hl,
                                input cu_state_e st);
        exp_t e;
        e = '{irl, pcl, jmp, mi, mw, as, al, sb, hl, st};
        return e;
    endfunction

    // Control word each instruction phase must show, straight from the
    // instruction-set table.
    function automatic exp_t e_start();
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, ST_START);
    endfunction
    function automatic exp_t e_fetch();
        return mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, ST_FETCH);
    endfunction
    function automatic exp_t e_decode();
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, ST_DECODE);
    endfunction
    function automatic exp_t e_exec(input logic [2:0] op, input logic aq,
                                    input logic ap, input logic en);
        logic al_in;
`ifdef CU_ENTER_HANDSHAKE_EN
        al_in = en;
`else
        al_in = 1'b1;
`endif
        case (op)
            OP_LOAD:  return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ASEL_MEM,   1'b1, 1'b0, 1'b0, ST_LOAD);
            OP_STORE: return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00,      1'b0, 1'b0, 1'b0, ST_STORE);
            OP_ADD:   return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ASEL_ALU,   1'b1, 1'b0, 1'b0, ST_ADD);
            OP_SUB:   return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ASEL_ALU,   1'b1, 1'b1, 1'b0, ST_SUB);
            OP_INPUT: return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ASEL_INPUT, al_in, 1'b0, 1'b0, ST_INPUT);
            OP_JZ:    return mk(1'b0, aq,   1'b1, 1'b0, 1'b0, 2'b00,      1'b0, 1'b0, 1'b0, ST_JZ);
            OP_JPOS:  return mk(1'b0, ap,   1'b1, 1'b0, 1'b0, 2'b00,      1'b0, 1'b0, 1'b0, ST_JPOS);
            default:  return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00,      1'b0, 1'b0, 1'b1, ST_HALT);
        endcase
    endfunction

    // One clock cycle: drive inputs at negedge and queue what the DUT must show.
    task automatic step(input string nm, input exp_t e, input logic rst,
                        input logic [2:0] op, input logic aq, input logic ap,
                        input logic en);
        @(negedge clk);
        reset  = rst;
        opcode = op;
        Aeq0   = aq;
        Apos   = ap;
        Enter  = en;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Fetch/decode/execute with flags inverted outside the execute cycle so
    // that any sampling of them in the wrong state shows up.
    task automatic run_instr(input string nm, input logic [2:0] op, input logic aq,
                             input logic ap, input int nwait);
        step({nm, "_fetch"}, e_fetch(), 1'b1, op ^ 3'b111, ~aq, ~ap, 1'b0);
        #3 check({nm, "_fetch_lit"}, act, 14'h3401);
        step({nm, "_decode"}, e_decode(), 1'b1, op, ~aq, ~ap, 1'b0);
        if (op == OP_INPUT) begin
`ifdef CU_ENTER_HANDSHAKE_EN
            for (int i = 0; i < nwait; i++)
                step({nm, "_wait"}, e_exec(op, aq, ap, 1'b0), 1'b1, op ^ 3'b011, aq, ap, 1'b0);
            step({nm, "_exec"}, e_exec(op, aq, ap, 1'b1), 1'b1, op ^ 3'b011, aq, ap, 1'b1);
`else
            step({nm, "_exec"}, e_exec(op, aq, ap, 1'b0), 1'b1, op ^ 3'b011, aq, ap, 1'b0);
`endif
        end else begin
            step({nm, "_exec"}, e_exec(op, aq, ap, 1'b0), 1'b1, op ^ 3'b011, aq, ap, 1'b0);
        end
    endtask

    task automatic do_reset();
        step("rst_low0", e_start(), 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        step("rst_low1", e_start(), 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        step("rst_release", e_start(), 1'b1, 3'b001, 1'b0, 1'b0, 1'b0);
        step("start_sync", e_start(), 1'b1, 3'b001, 1'b0, 1'b0, 1'b0);
    endtask

    // Single compare process: every queued cycle plus the structural invariants.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check(nm, act, e);
                check({nm, "_asel11_or_wr_ld"},
                      {13'd0, (Asel == 2'b11) || (MemWr && Aload)}, 14'd0);
            end
        end
    end

    initial begin
        reset = 1'b1; opcode = 3'b000; Aeq0 = 1'b0; Apos = 1'b0; Enter = 1'b0;
        #1 reset = 1'b0;
        #1 check("reset_lit", act, 14'h0000);
        do_reset();
        run_instr("load", OP_LOAD, 1'b0, 1'b0, 0);
        run_instr("store", OP_STORE, 1'b1, 1'b0, 0);
        run_instr("sub", OP_SUB, 1'b0, 1'b1, 0);
        run_instr("add", OP_ADD, 1'b1, 1'b1, 0);
        run_instr("jz_taken", OP_JZ, 1'b1, 1'b0, 0);
        run_instr("jz_not", OP_JZ, 1'b0, 1'b1, 0);
        run_instr("jpos_taken", OP_JPOS, 1'b0, 1'b1, 0);
        run_instr("jpos_not", OP_JPOS, 1'b1, 1'b0, 0);
        run_instr("input_wait4", OP_INPUT, 1'b0, 1'b0, 4);
        run_instr("input_now", OP_INPUT, 1'b0, 1'b0, 0);
        run_instr("load2", OP_LOAD, 1'b1, 1'b1, 0);

        // Reset asserted in the middle of an INPUT cycle.
        step("in2_fetch", e_fetch(), 1'b1, OP_INPUT, 1'b0, 1'b0, 1'b0);
        step("in2_decode", e_decode(), 1'b1, OP_INPUT, 1'b0, 1'b0, 1'b0);
        step("in2_exec", e_exec(OP_INPUT, 1'b0, 1'b0, 1'b0), 1'b1, OP_INPUT, 1'b0, 1'b0, 1'b0);
        #3 reset = 1'b0;
        #1 check("reset_mid_input", act, 14'h0000);
        do_reset();
        run_instr("add2", OP_ADD, 1'b0, 1'b0, 0);

        // HALT holds for 10 cycles whatever the inputs do.
        step("halt_fetch", e_fetch(), 1'b1, OP_HALT, 1'b0, 1'b0, 1'b0);
        step("halt_decode", e_decode(), 1'b1, OP_HALT, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step("halt_hold", e_exec(OP_HALT, 1'b0, 1'b0, 1'b0), 1'b1,
                 3'(i), i[0], i[1], i[0]);
            if (i == 0) begin
                #3 check("halt_lit", act, 14'h001A);
            end
        end
        #3 reset = 1'b0;
        #1 check("reset_mid_halt", act, 14'h0000);
        step("halt_rst", e_start(), 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
